// File: rtl/snake_field_engine_if.sv
// Interface bundle for snake_field_engine.
//
// Groups the engine's control inputs and display/status outputs so they travel
// together. The clock and reset are plain ports on the engine, not part of
// this bundle.
//   master : drives tick, dir and the apple position; observes pixels and status
//   slave  : the engine side
interface snake_field_engine_if #(
    parameter int unsigned ROWS    = 16,
    parameter int unsigned COLS    = 16,
    parameter int unsigned MAX_LEN = 32
);
    localparam int unsigned RW = $clog2(ROWS);
    localparam int unsigned CW = $clog2(COLS);
    localparam int unsigned LW = $clog2(MAX_LEN + 1);

    logic                      tick;
    logic [1:0]                dir;
    logic                      apple_valid;
    logic [RW-1:0]             apple_row;
    logic [CW-1:0]             apple_col;
    logic [ROWS-1:0][COLS-1:0] RedPixels;
    logic [ROWS-1:0][COLS-1:0] GrnPixels;
    logic [RW-1:0]             head_row;
    logic [CW-1:0]             head_col;
    logic [LW-1:0]             length;
    logic                      ate;
    logic                      game_over;

    modport master (
        output tick, dir, apple_valid, apple_row, apple_col,
        input  RedPixels, GrnPixels, head_row, head_col, length, ate, game_over
    );

    modport slave (
        input  tick, dir, apple_valid, apple_row, apple_col,
        output RedPixels, GrnPixels, head_row, head_col, length, ate, game_over
    );
endinterface

// File: rtl/snake_field_engine.sv
// Snake playfield engine.
//
// Keeps the snake body in a circular buffer of coordinates plus a registered
// occupancy bitmap, advances one cell per tick and renders red/green pixel
// planes from registers only.
//
// Ports:
//   clk   : single clock, all logic on posedge
//   reset : synchronous, active-low; restores the start position from any state
//   bus   : snake_field_engine_if.slave
//           in  : tick, dir, apple_valid, apple_row, apple_col
//           out : RedPixels, GrnPixels, head_row, head_col, length, ate, game_over
//
// Build option:
//   SNAKE_WALL_WRAP_EN : when defined the head wraps around the field edges;
//                        otherwise stepping off an edge is a collision.
module snake_field_engine #(
    parameter int unsigned ROWS     = 16,
    parameter int unsigned COLS     = 16,
    parameter int unsigned MAX_LEN  = 32,
    parameter int unsigned INIT_LEN = 3
) (
    input logic                 clk,
    input logic                 reset,
    snake_field_engine_if.slave bus
);
    localparam int unsigned RW = $clog2(ROWS);
    localparam int unsigned CW = $clog2(COLS);
    localparam int unsigned PW = (MAX_LEN > 1) ? $clog2(MAX_LEN) : 1;
    localparam int unsigned LW = $clog2(MAX_LEN + 1);

    localparam logic [RW-1:0] StartRow = RW'(ROWS / 2 - 2);
    localparam logic [1:0]    DirLeft  = 2'd3;

`ifdef SNAKE_WALL_WRAP_EN
    localparam bit WrapEn = 1'b1;
`else
    localparam bit WrapEn = 1'b0;
`endif

    typedef enum logic [0:0] {StRun, StDead} state_e;

    state_e                    state_q, state_d;
    logic [RW-1:0]             body_row_q [MAX_LEN];
    logic [CW-1:0]             body_col_q [MAX_LEN];
    logic [PW-1:0]             head_ptr_q, tail_ptr_q;
    logic [PW-1:0]             head_ptr_nx, tail_ptr_nx;
    logic [1:0]                heading_q;
    logic [LW-1:0]             len_q;
    logic                      ate_q;
    logic [ROWS-1:0][COLS-1:0] occ_q, occ_d;
    logic [ROWS-1:0][COLS-1:0] apple_pix_q, apple_pix_d;
    logic [ROWS-1:0][COLS-1:0] head_pix;

    logic [RW-1:0] head_row, tail_row, next_row;
    logic [CW-1:0] head_col, tail_col, next_col;
    logic [1:0]    eff_dir;
    logic          off_edge, apple_hit, grow, tail_hit, hit_body, collide, step;

    assign head_row = body_row_q[head_ptr_q];
    assign head_col = body_col_q[head_ptr_q];
    assign tail_row = body_row_q[tail_ptr_q];
    assign tail_col = body_col_q[tail_ptr_q];

    assign head_ptr_nx = (head_ptr_q == PW'(MAX_LEN - 1)) ? '0 : head_ptr_q + 1'b1;
    assign tail_ptr_nx = (tail_ptr_q == PW'(MAX_LEN - 1)) ? '0 : tail_ptr_q + 1'b1;

    // Next head position; a reversal request keeps the current heading.
    always_comb begin
        eff_dir  = (bus.dir == (heading_q ^ 2'd2)) ? heading_q : bus.dir;
        next_row = head_row;
        next_col = head_col;
        off_edge = 1'b0;
        case (eff_dir)
            2'd0: begin
                if (head_row == '0) begin
                    if (WrapEn) next_row = RW'(ROWS - 1);
                    else        off_edge = 1'b1;
                end else begin
                    next_row = head_row - 1'b1;
                end
            end
            2'd1: begin
                if (head_col == CW'(COLS - 1)) begin
                    if (WrapEn) next_col = '0;
                    else        off_edge = 1'b1;
                end else begin
                    next_col = head_col + 1'b1;
                end
            end
            2'd2: begin
                if (head_row == RW'(ROWS - 1)) begin
                    if (WrapEn) next_row = '0;
                    else        off_edge = 1'b1;
                end else begin
                    next_row = head_row + 1'b1;
                end
            end
            default: begin
                if (head_col == '0) begin
                    if (WrapEn) next_col = CW'(COLS - 1);
                    else        off_edge = 1'b1;
                end else begin
                    next_col = head_col - 1'b1;
                end
            end
        endcase
    end

    // A full-length snake still eats but no longer grows.
    always_comb begin
        apple_hit = bus.apple_valid && (next_row == bus.apple_row) &&
                    (next_col == bus.apple_col);
        grow      = apple_hit && (len_q != LW'(MAX_LEN));
        tail_hit  = (next_row == tail_row) && (next_col == tail_col);
        // The tail cell vacates on the same step, so it is free unless we grow.
        hit_body  = occ_q[next_row][next_col] && (grow || !tail_hit);
        collide   = off_edge || hit_body;
        step      = bus.tick && (state_q == StRun) && !collide;
    end

    // Tail clear first so a head moving into the old tail cell stays set.
    always_comb begin
        occ_d = occ_q;
        if (!grow) occ_d[tail_row][tail_col] = 1'b0;
        occ_d[next_row][next_col] = 1'b1;
    end

    always_comb begin
        apple_pix_d = '0;
        if (bus.apple_valid) apple_pix_d[bus.apple_row][bus.apple_col] = 1'b1;
    end

    always_comb begin
        state_d = state_q;
        if ((state_q == StRun) && bus.tick && collide) state_d = StDead;
    end

    always_ff @(posedge clk) begin
        if (!reset) state_q <= StRun;
        else        state_q <= state_d;
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            head_ptr_q  <= PW'(INIT_LEN - 1);
            tail_ptr_q  <= '0;
            heading_q   <= DirLeft;
            len_q       <= LW'(INIT_LEN);
            ate_q       <= 1'b0;
            apple_pix_q <= apple_pix_d;
            occ_q       <= '0;
            // Entry 0 is the tail at the far right; the head sits at COLS/2.
            for (int unsigned i = 0; i < MAX_LEN; i++) begin
                body_row_q[i] <= StartRow;
                if (i < INIT_LEN) body_col_q[i] <= CW'(COLS / 2 + INIT_LEN - 1 - i);
                else              body_col_q[i] <= '0;
            end
            for (int unsigned i = 0; i < INIT_LEN; i++) begin
                occ_q[StartRow][CW'(COLS / 2 + i)] <= 1'b1;
            end
        end else begin
            ate_q <= 1'b0;
            // Apple display freezes once dead, including on the fatal step.
            if (state_d == StRun) apple_pix_q <= apple_pix_d;
            if (step) begin
                head_ptr_q              <= head_ptr_nx;
                body_row_q[head_ptr_nx] <= next_row;
                body_col_q[head_ptr_nx] <= next_col;
                heading_q               <= eff_dir;
                ate_q                   <= apple_hit;
                occ_q                   <= occ_d;
                if (grow) len_q      <= len_q + 1'b1;
                else      tail_ptr_q <= tail_ptr_nx;
            end
        end
    end

    always_comb begin
        head_pix                     = '0;
        head_pix[head_row][head_col] = 1'b1;
    end

    assign bus.GrnPixels = occ_q;
    assign bus.RedPixels = (occ_q & ~head_pix) | apple_pix_q;
    assign bus.head_row  = head_row;
    assign bus.head_col  = head_col;
    assign bus.length    = len_q;
    assign bus.ate       = ate_q;
    assign bus.game_over = (state_q == StDead);
endmodule

// File: tb/tb_snake_field_engine.sv
// Self-checking bench for snake_field_engine: directed scenarios followed by
// randomized play, all checked against a queue-based snake model.
module tb_snake_field_engine;
    localparam int ROWS     = 16;
    localparam int COLS     = 16;
    localparam int MAX_LEN  = 32;
    localparam int INIT_LEN = 3;
    localparam int NPIX     = ROWS * COLS;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    snake_field_engine_if #(.ROWS(ROWS), .COLS(COLS), .MAX_LEN(MAX_LEN)) bus ();

    snake_field_engine #(
        .ROWS    (ROWS),
        .COLS    (COLS),
        .MAX_LEN (MAX_LEN),
        .INIT_LEN(INIT_LEN)
    ) dut (
        .clk  (clk),
        .reset(reset),
        .bus  (bus)
    );

    int n_tests = 0;
    int n_fail  = 0;

    // Model: snake as a queue of cells, index 0 is the head.
    int q_r[$];
    int q_c[$];
    int m_heading;
    bit m_dead;
    bit m_ate;
    bit m_av;
    int m_ar;
    int m_ac;

    task automatic check(input string tag, input logic [NPIX-1:0] got,
                         input logic [NPIX-1:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic model_reset();
        q_r.delete();
        q_c.delete();
        for (int i = 0; i < INIT_LEN; i++) begin
            q_r.push_back(ROWS / 2 - 2);
            q_c.push_back(COLS / 2 + i);
        end
        m_heading = 3;
        m_dead    = 1'b0;
        m_ate     = 1'b0;
        m_av      = bus.apple_valid;
        m_ar      = int'(bus.apple_row);
        m_ac      = int'(bus.apple_col);
    endtask

    task automatic model_step();
        int d, nr, nc, lim;
        bit off, hit, grow, coll;
        m_ate = 1'b0;
        if (reset == 1'b0) begin
            model_reset();
        end else begin
            if (bus.tick && !m_dead) begin
                d = (int'(bus.dir) == (m_heading + 2) % 4) ? m_heading : int'(bus.dir);
                nr = q_r[0];
                nc = q_c[0];
                case (d)
                    0:       nr = nr - 1;
                    1:       nc = nc + 1;
                    2:       nr = nr + 1;
                    default: nc = nc - 1;
                endcase
                off = (nr < 0) || (nr >= ROWS) || (nc < 0) || (nc >= COLS);
`ifdef SNAKE_WALL_WRAP_EN
                nr  = (nr + ROWS) % ROWS;
                nc  = (nc + COLS) % COLS;
                off = 1'b0;
`endif
                hit  = bus.apple_valid && (nr == int'(bus.apple_row)) &&
                       (nc == int'(bus.apple_col));
                grow = hit && (q_r.size() < MAX_LEN);
                lim  = grow ? q_r.size() : q_r.size() - 1;
                coll = off;
                for (int i = 0; i < lim; i++)
                    if (q_r[i] == nr && q_c[i] == nc) coll = 1'b1;
                if (coll) begin
                    m_dead = 1'b1;
                end else begin
                    q_r.push_front(nr);
                    q_c.push_front(nc);
                    if (!grow) begin
                        void'(q_r.pop_back());
                        void'(q_c.pop_back());
                    end
                    m_heading = d;
                    m_ate     = hit;
                end
            end
            if (!m_dead) begin
                m_av = bus.apple_valid;
                m_ar = int'(bus.apple_row);
                m_ac = int'(bus.apple_col);
            end
        end
    endtask

    function automatic logic [NPIX-1:0] exp_grn();
        logic [NPIX-1:0] v = '0;
        for (int i = 0; i < q_r.size(); i++) v[q_r[i] * COLS + q_c[i]] = 1'b1;
        return v;
    endfunction

    function automatic logic [NPIX-1:0] exp_red();
        logic [NPIX-1:0] v = '0;
        for (int i = 1; i < q_r.size(); i++) v[q_r[i] * COLS + q_c[i]] = 1'b1;
        if (m_av) v[m_ar * COLS + m_ac] = 1'b1;
        return v;
    endfunction

    task automatic check_all(input string tag);
        check({tag, "_head_row"}, bus.head_row, q_r[0]);
        check({tag, "_head_col"}, bus.head_col, q_c[0]);
        check({tag, "_length"}, bus.length, q_r.size());
        check({tag, "_ate"}, bus.ate, m_ate);
        check({tag, "_game_over"}, bus.game_over, m_dead);
        check({tag, "_grn"}, bus.GrnPixels, exp_grn());
        check({tag, "_red"}, bus.RedPixels, exp_red());
    endtask

    // One clock: drive inputs, step DUT and model together, compare after the edge.
    task automatic cycle(input bit rst_n, input bit tk, input int d, input bit av,
                         input int ar, input int ac, input string tag);
        reset           = rst_n;
        bus.tick        = tk;
        bus.dir         = d[1:0];
        bus.apple_valid = av;
        bus.apple_row   = ar[3:0];
        bus.apple_col   = ac[3:0];
        @(posedge clk);
        model_step();
        #1;
        check_all(tag);
    endtask

    initial begin
        int ar, ac;
        bit rst_n;
        reset           = 1'b0;
        bus.tick        = 1'b0;
        bus.dir         = 2'd3;
        bus.apple_valid = 1'b0;
        bus.apple_row   = '0;
        bus.apple_col   = '0;

        // Reset state.
        cycle(0, 0, 3, 0, 0, 0, "reset");
        check("reset_head_row_c", bus.head_row, 6);
        check("reset_head_col_c", bus.head_col, 8);
        check("reset_len_c", bus.length, 3);
        check("reset_go_c", bus.game_over, 0);
        check("reset_grn6_c", bus.GrnPixels[6], 16'h0700);
        check("reset_red6_c", bus.RedPixels[6], 16'h0600);

        // Three left steps.
        for (int i = 0; i < 3; i++) cycle(1, 1, 3, 0, 0, 0, "left3");
        check("left3_head_col_c", bus.head_col, 5);
        check("left3_len_c", bus.length, 3);
        check("left3_grn6_c", bus.GrnPixels[6], 16'h00E0);
        check("left3_red6_c", bus.RedPixels[6], 16'h00C0);

        // Eat an apple directly ahead.
        cycle(0, 0, 3, 0, 0, 0, "rst_eat");
        cycle(1, 1, 3, 1, 6, 7, "eat");
        check("eat_ate_c", bus.ate, 1);
        check("eat_len_c", bus.length, 4);
        check("eat_grn6_c", bus.GrnPixels[6], 16'h0780);
        cycle(1, 0, 3, 0, 0, 0, "eat_after");
        check("eat_pulse_c", bus.ate, 0);

        // Reversal right after reset is ignored.
        cycle(0, 0, 3, 0, 0, 0, "rst_rev");
        cycle(1, 1, 1, 0, 0, 0, "rev");
        check("rev_head_row_c", bus.head_row, 6);
        check("rev_head_col_c", bus.head_col, 7);

        // Run into the left edge.
        cycle(0, 0, 3, 0, 0, 0, "rst_wall");
        for (int i = 0; i < 8; i++) cycle(1, 1, 3, 0, 0, 0, "wall8");
        check("wall8_head_col_c", bus.head_col, 0);
        cycle(1, 1, 3, 0, 0, 0, "wall9");
`ifdef SNAKE_WALL_WRAP_EN
        check("wall9_head_col_c", bus.head_col, 15);
        check("wall9_go_c", bus.game_over, 0);
`else
        check("wall9_head_col_c", bus.head_col, 0);
        check("wall9_go_c", bus.game_over, 1);
`endif

        // Grow to five, then U-turn into the body.
        cycle(0, 0, 3, 0, 0, 0, "rst_u");
        cycle(1, 1, 3, 1, 6, 7, "u_eat1");
        cycle(1, 1, 3, 1, 6, 6, "u_eat2");
        cycle(1, 1, 0, 0, 0, 0, "u_up");
        cycle(1, 1, 1, 0, 0, 0, "u_right");
        cycle(1, 1, 2, 0, 0, 0, "u_down");
        check("u_go_c", bus.game_over, 1);
        check("u_len_c", bus.length, 5);
        check("u_head_row_c", bus.head_row, 5);
        check("u_head_col_c", bus.head_col, 7);
        for (int i = 0; i < 3; i++) cycle(1, 1, $urandom_range(0, 3), 0, 0, 0, "u_frozen");
        check("u_grn5_c", bus.GrnPixels[5], 16'h00C0);
        check("u_grn6_c", bus.GrnPixels[6], 16'h01C0);
        check("u_red5_c", bus.RedPixels[5], 16'h0040);

        // Randomized play.
        for (int n = 0; n < 3000; n++) begin
            rst_n = !(($urandom_range(0, 99) < 2) || (m_dead && $urandom_range(0, 7) == 0));
            if ($urandom_range(0, 1) == 1) begin
                ar = (q_r[0] + int'($urandom_range(0, 2)) + ROWS - 1) % ROWS;
                ac = (q_c[0] + int'($urandom_range(0, 2)) + COLS - 1) % COLS;
            end else begin
                ar = int'($urandom_range(0, ROWS - 1));
                ac = int'($urandom_range(0, COLS - 1));
            end
            cycle(rst_n, $urandom_range(0, 1) == 1, int'($urandom_range(0, 3)),
                  $urandom_range(0, 3) != 0, ar, ac, "rand");
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule

// File: doc/snake_field_engine.md
SNAKE_FIELD_ENGINE -- requirements
Module: snake_field_engine

Interface
REQ-001 SHALL have parameter ROWS, default 16, meaning playfield rows.
REQ-002 SHALL have parameter COLS, default 16, meaning playfield columns.
REQ-003 SHALL have parameter MAX_LEN, default 32, meaning snake body buffer depth; valid range is INIT_LEN..ROWS*COLS.
REQ-004 SHALL have parameter INIT_LEN, default 3, meaning snake length after reset; valid range is 2..COLS/2.
REQ-005 SHALL have port clk, input, 1 bit: the single clock; all logic is on posedge.
REQ-006 SHALL have port reset, input, 1 bit: synchronous, active-low reset.
REQ-007 SHALL have port tick, input, 1 bit: advance the snake one step.
REQ-008 SHALL have port dir, input, 2 bits: requested heading (0 up = row-1, 1 right = col+1, 2 down = row+1, 3 left = col-1).
REQ-009 SHALL have ports apple_valid (input, 1 bit), apple_row (input, clog2(ROWS) bits) and apple_col (input, clog2(COLS) bits): the apple position.
REQ-010 SHALL have ports RedPixels and GrnPixels, output, [ROWS][COLS] bits each, indexed [row][col].
REQ-011 SHALL have ports head_row and head_col, output, with the same widths as apple_row and apple_col: current head position.
REQ-012 SHALL have port length, output, clog2(MAX_LEN+1) bits: current snake length.
REQ-013 SHALL have port ate, output, 1 bit: one-cycle pulse when the apple is eaten.
REQ-014 SHALL have port game_over, output, 1 bit: high while in state DEAD.

Function
REQ-015 SHALL hold body coordinates in a circular buffer of MAX_LEN entries with head and tail pointers, both wrapping modulo MAX_LEN.
REQ-016 SHALL keep a registered occupancy bitmap with one bit per cell; pixels are driven from registers only, with no combinational path from inputs to pixels.
REQ-017 SHALL render pixels as follows: head cell = green only; body cells = red and green; apple cell, when apple_valid, = red only; all other cells off.
REQ-018 SHALL implement state machine RUN to DEAD: tick in RUN with a collision goes to DEAD; DEAD is left only by reset; tick in DEAD is ignored and the pixels freeze.
REQ-019 SHALL sample tick and dir on the same edge, with state, pointers, pixels, head and length updated on that edge; latency is 1 cycle from tick to outputs.
REQ-020 SHALL ignore a requested dir that is the exact reverse of the current heading, keeping the current heading.
REQ-021 SHALL treat the next head as a growth step when apple_valid is high and next head equals (apple_row, apple_col).
REQ-022 SHALL, on a non-growth step, clear the tail occupancy bit, advance the tail pointer, and set the new head bit.
REQ-023 SHALL, on a growth step, assert ate for exactly 1 cycle and increment length with the tail held, saturating at MAX_LEN; at MAX_LEN ate still pulses and the step behaves as a non-growth step.
REQ-024 SHALL detect self-collision when the next head hits an occupied cell, excluding the current tail cell on a non-growth step.
REQ-025 SHALL, on collision, leave the body, length and pixels unchanged and set game_over on the next cycle.
REQ-026 SHALL ignore tick held high for multiple cycles only in the sense that it produces one step per high cycle; edge detection is the user's responsibility.

Reset
REQ-027 SHALL, while reset is low at posedge, load head at (ROWS/2-2, COLS/2), body at columns COLS/2+1 .. COLS/2+INIT_LEN-1 on the same row, heading left, length=INIT_LEN, state RUN, ate=0, game_over=0.
REQ-028 SHALL produce the following pixels after reset with 16x16 defaults: GrnPixels[6] bits 8,9,10 set; RedPixels[6] bits 9,10 set; plus the apple pixel if apple_valid.
REQ-029 SHALL let reset override a simultaneous tick and abort any state, including DEAD.

Configuration
REQ-030 SHALL, with macro SNAKE_WALL_WRAP_EN defined, wrap the head at edges (row 0 up goes to ROWS-1, col COLS-1 right goes to 0, and likewise for the other edges) with no wall collision.
REQ-031 SHALL, without SNAKE_WALL_WRAP_EN, treat a step off any edge as a collision, leading to DEAD with pixels unchanged.

Verification
REQ-032 SHALL cover: reset low for 1 cycle -> head (6,8), length 3, pixel rows match REQ-028, game_over=0.
REQ-033 SHALL cover: dir=3 with 3 ticks -> head (6,5), length 3, cells (6,8..10) cleared except body at (6,6),(6,7).
REQ-034 SHALL cover: apple (6,7) valid, dir=3, one tick -> ate pulses 1 cycle, length 4, tail still at (6,10).
REQ-035 SHALL cover: dir=1 (the reverse) plus a tick right after reset -> head (6,7), reversal ignored.
REQ-036 SHALL cover: 8 left ticks from reset -> without the macro, the 9th tick sets game_over=1 with head (6,0); with SNAKE_WALL_WRAP_EN, head becomes (6,15).
REQ-037 SHALL cover: a length-5 snake steered into a U-turn onto its body -> game_over=1, and further ticks leave pixels constant.
